// File: rtl/ex_mem_if.sv
// EX->MEM stage bundle: EX-side inputs, MEM-side outputs,
// branch redirect and overflow-exception signalling.
interface ex_mem_if #(
  parameter int DW    = 32,
  parameter int RW    = 5,
  parameter int CNT_W = 16
) ();
  logic          stall;
  logic          flush;
  logic          ex_valid;
  logic [DW-1:0] ex_alu_res;
  logic          ex_zero;
  logic          ex_overflow;
  logic          ex_ovf_trap;
  logic          ex_beq;
  logic          ex_bne;
  logic [DW-1:0] ex_br_target;
  logic [DW-1:0] ex_pc;
  logic [DW-1:0] ex_rt_data;
  logic [RW-1:0] ex_wreg;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          exc_ack;

  logic             mem_valid;
  logic [DW-1:0]    mem_alu_res;
  logic [DW-1:0]    mem_rt_data;
  logic [RW-1:0]    mem_wreg;
  logic             mem_reg_write;
  logic             mem_mem_read;
  logic             mem_mem_write;
  logic             br_taken;
  logic [DW-1:0]    br_target;
  logic             exc_req;
  logic [DW-1:0]    epc;
  logic             flush_up;
  logic [CNT_W-1:0] ovf_count;

  modport master (
    output stall, flush, ex_valid, ex_alu_res, ex_zero,
    output ex_overflow, ex_ovf_trap, ex_beq, ex_bne,
    output ex_br_target, ex_pc, ex_rt_data, ex_wreg,
    output ex_reg_write, ex_mem_read, ex_mem_write, exc_ack,
    input  mem_valid, mem_alu_res, mem_rt_data, mem_wreg,
    input  mem_reg_write, mem_mem_read, mem_mem_write,
    input  br_taken, br_target, exc_req, epc, flush_up,
    input  ovf_count
  );

  modport slave (
    input  stall, flush, ex_valid, ex_alu_res, ex_zero,
    input  ex_overflow, ex_ovf_trap, ex_beq, ex_bne,
    input  ex_br_target, ex_pc, ex_rt_data, ex_wreg,
    input  ex_reg_write, ex_mem_read, ex_mem_write, exc_ack,
    output mem_valid, mem_alu_res, mem_rt_data, mem_wreg,
    output mem_reg_write, mem_mem_read, mem_mem_write,
    output br_taken, br_target, exc_req, epc, flush_up,
    output ovf_count
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with branch resolve and a
// RUN/TRAP overflow-exception FSM.
module ex_mem_stage #(
  parameter int DW    = 32,
  parameter int RW    = 5,
  parameter int CNT_W = 16
) (
  input logic     clk,
  input logic     rst,
  ex_mem_if.slave bus
);

  typedef enum logic {RUN, TRAP} state_t;

  state_t state, state_nxt;
  logic   take, trap, taken;
  logic   rw_q, mr_q, mw_q;

  always_comb begin
    take = bus.ex_valid & ~bus.stall & ~bus.flush
         & (state == RUN);
    trap = take & bus.ex_ovf_trap & bus.ex_overflow;
    taken = (bus.ex_beq & bus.ex_zero)
          | (bus.ex_bne & ~bus.ex_zero);
    state_nxt = state;
    case (state)
      RUN:     if (trap) state_nxt = TRAP;
      TRAP:    if (bus.exc_ack) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_valid   <= 1'b0;
      bus.mem_alu_res <= DW'(0);
      bus.mem_rt_data <= DW'(0);
      bus.mem_wreg    <= RW'(0);
      rw_q            <= 1'b0;
      mr_q            <= 1'b0;
      mw_q            <= 1'b0;
      bus.br_taken    <= 1'b0;
      bus.br_target   <= DW'(0);
      bus.epc         <= DW'(0);
      bus.ovf_count   <= CNT_W'(0);
    end else begin
      // a trapping instruction never redirects fetch
      bus.br_taken <= take & ~trap & taken;
      if (take) bus.br_target <= bus.ex_br_target;
      if (state == TRAP || bus.flush) begin
        bus.mem_valid <= 1'b0;
      end else if (!bus.stall) begin
        if (trap) begin
          bus.mem_valid <= 1'b0;
          bus.epc       <= bus.ex_pc;
          if (~&bus.ovf_count)
            bus.ovf_count <= bus.ovf_count + CNT_W'(1);
        end else if (take) begin
          bus.mem_valid   <= 1'b1;
          bus.mem_alu_res <= bus.ex_alu_res;
          bus.mem_rt_data <= bus.ex_rt_data;
          bus.mem_wreg    <= bus.ex_wreg;
          rw_q            <= bus.ex_reg_write;
          mr_q            <= bus.ex_mem_read;
          mw_q            <= bus.ex_mem_write;
        end else begin
          bus.mem_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.mem_reg_write = bus.mem_valid & rw_q;
  assign bus.mem_mem_read  = bus.mem_valid & mr_q;
  assign bus.mem_mem_write = bus.mem_valid & mw_q;
  assign bus.exc_req       = (state == TRAP);
  assign bus.flush_up      = (state == TRAP);

endmodule
